// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate for conv engines: registered operands,
// MUL_STAGES product stages, framed window accumulator, rounded/saturated output.
module cnn_mac_pipe #(
  parameter int A_W        = 14,
  parameter int B_W        = 10,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat,
  output logic                    ovf
);

  localparam int P_W = A_W + B_W;

  if (ACC_W < P_W || OUT_W > ACC_W || MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_cfg_err
    $error("cnn_mac_pipe: illegal configuration (ACC_W/OUT_W/MUL_STAGES)");
  end

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  v_q, f_q, l_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
      f_q <= 1'b0;
      l_q <= 1'b0;
    end else if (ce) begin
      a_q <= din0;
      b_q <= din1;
      v_q <= in_valid;
      f_q <= in_first;
      l_q <= in_last;
    end
  end

  logic signed [P_W-1:0] a_ext, b_ext, prod;
  assign a_ext = P_W'(a_q);
  assign b_ext = P_W'(b_q);
  assign prod  = a_ext * b_ext;

  logic signed [P_W-1:0] p_q  [MUL_STAGES];
  logic                  pv_q [MUL_STAGES];
  logic                  pf_q [MUL_STAGES];
  logic                  pl_q [MUL_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        p_q[i]  <= '0;
        pv_q[i] <= 1'b0;
        pf_q[i] <= 1'b0;
        pl_q[i] <= 1'b0;
      end
    end else if (ce) begin
      p_q[0]  <= prod;
      pv_q[0] <= v_q;
      pf_q[0] <= f_q;
      pl_q[0] <= l_q;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        p_q[i]  <= p_q[i-1];
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
    end
  end

  logic signed [ACC_W-1:0] acc_q, p_ext, sum;
  logic                    sticky_q, need_first_q, emit_q, add_ovf;

  assign p_ext = ACC_W'(p_q[MUL_STAGES-1]);

  always_comb begin
    sum     = acc_q + p_ext;
    add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  end

  // need_first_q forces the first valid beat after reset to open a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      need_first_q <= 1'b1;
      emit_q       <= 1'b0;
    end else if (ce) begin
      emit_q <= pv_q[MUL_STAGES-1] & pl_q[MUL_STAGES-1];
      if (pv_q[MUL_STAGES-1]) begin
        need_first_q <= 1'b0;
        if (pf_q[MUL_STAGES-1] || need_first_q) begin
          acc_q    <= p_ext;
          sticky_q <= 1'b0;
        end else begin
          acc_q    <= sum;
          sticky_q <= sticky_q | add_ovf;
        end
      end
    end
  end

  logic signed [ACC_W:0] acc_x, r;
  assign acc_x = (ACC_W+1)'(acc_q);

  if (SHIFT == 0) begin : g_noround
    assign r = acc_x;
  end else begin : g_round
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (SHIFT-1);
    assign r = (acc_x + HALF) >>> SHIFT;
  end

  localparam longint                 MAX_L = (longint'(1) <<< (OUT_W-1)) - 1;
  localparam logic signed [ACC_W:0] MAXV  = (ACC_W+1)'(MAX_L);
  localparam logic signed [ACC_W:0] MINV  = (ACC_W+1)'(-MAX_L - 1);

  logic signed [OUT_W-1:0] dout_n;
  logic                    sat_n;

  always_comb begin
    dout_n = OUT_W'(r);
    sat_n  = 1'b0;
    if (r > MAXV) begin
      dout_n = OUT_W'(MAXV);
      sat_n  = 1'b1;
    end else if (r < MINV) begin
      dout_n = OUT_W'(MINV);
      sat_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= emit_q;
      if (emit_q) begin
        dout <= dout_n;
        sat  <= sat_n;
        ovf  <= sticky_q;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Randomized self-checking bench for cnn_mac_pipe against a window-sum reference
// model that tracks expected strobe timing in enabled clock edges.
module tb_cnn_mac_pipe;

  logic                clk = 1'b0;
  logic                reset, ce, in_valid, in_first, in_last;
  logic signed [13:0]  din0;
  logic signed [9:0]   din1;
  logic                out_valid, sat, ovf;
  logic signed [15:0]  dout;

  cnn_mac_pipe #(
    .A_W(14), .B_W(10), .ACC_W(32), .OUT_W(16), .SHIFT(8), .MUL_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid),
    .dout(dout), .sat(sat), .ovf(ovf)
  );

  always #5 clk = ~clk;

  localparam int unsigned LAT = 4;

  typedef struct {
    int unsigned due;
    longint      d;
    bit          s;
    bit          o;
  } exp_t;

  exp_t        pend[$];
  longint      m_acc;
  bit          m_st, m_need;
  int unsigned cnt;
  bit          e_valid, e_sat, e_ovf;
  longint      e_dout;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_st = 1'b0;
    m_need = 1'b1;
    pend.delete();
    e_valid = 1'b0;
    e_dout = 0;
    e_sat = 1'b0;
    e_ovf = 1'b0;
  endtask

  task automatic accept(input longint a, input longint b, input bit f, input bit l);
    longint p, t, q;
    exp_t   e;
    p = a * b;
    if (f || m_need) begin
      m_acc = p;
      m_st = 1'b0;
    end else begin
      t = m_acc + p;
      if (t > 64'sd2147483647) begin
        t = t - 64'sd4294967296;
        m_st = 1'b1;
      end else if (t < -64'sd2147483648) begin
        t = t + 64'sd4294967296;
        m_st = 1'b1;
      end
      m_acc = t;
    end
    m_need = 1'b0;
    if (l) begin
      t = m_acc + 128;
      q = t / 256;
      if (t < 0 && (t % 256) != 0) q = q - 1;
      e.due = cnt + LAT;
      e.o = m_st;
      if (q > 32767) begin
        e.d = 32767;
        e.s = 1'b1;
      end else if (q < -32768) begin
        e.d = -32768;
        e.s = 1'b1;
      end else begin
        e.d = q;
        e.s = 1'b0;
      end
      pend.push_back(e);
    end
  endtask

  task automatic cycle(input bit v, input bit f, input bit l,
                       input longint a, input longint b, input bit c);
    logic signed [13:0] a14;
    logic signed [9:0]  b10;
    a14 = 14'(a);
    b10 = 10'(b);
    in_valid = v;
    in_first = f;
    in_last  = l;
    din0     = a14;
    din1     = b10;
    ce       = c;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (c) begin
      cnt++;
      if (v) accept(longint'(a14), longint'(b10), f, l);
      if (pend.size() > 0 && pend[0].due == cnt) begin
        e_valid = 1'b1;
        e_dout  = pend[0].d;
        e_sat   = pend[0].s;
        e_ovf   = pend[0].o;
        void'(pend.pop_front());
      end else begin
        e_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("out_valid", longint'(out_valid), longint'(e_valid));
    check("dout", longint'(dout), e_dout);
    check("sat", longint'(sat), longint'(e_sat));
    check("ovf", longint'(ovf), longint'(e_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic window(input longint a, input longint b, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, i == 0, i == n - 1, a, b, 1'b1);
  endtask

  task automatic async_reset();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_dout", longint'(dout), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_ovf", longint'(ovf), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  longint sa[6];
  longint sb[6];

  initial begin
    reset = 1'b1;
    ce = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    din0 = '0;
    din1 = '0;
    cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_dout", longint'(dout), 0);
    check("reset_sat", longint'(sat), 0);
    check("reset_ovf", longint'(ovf), 0);
    reset = 1'b0;

    cycle(1'b1, 1'b1, 1'b1, 1000, -256, 1'b1);
    idle(5);

    cycle(1'b1, 1'b1, 1'b1, 1, 127, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1, 128, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, -1, 128, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, -1, 129, 1'b1);
    idle(5);

    window(8191, 511, 9);
    window(-8192, 511, 9);
    idle(5);

    window(-8192, -512, 512);
    cycle(1'b1, 1'b1, 1'b1, 4, 64, 1'b1);
    idle(5);

    for (int i = 0; i < 6; i++) begin
      sa[i] = longint'($urandom_range(0, 16383)) - 8192;
      sb[i] = longint'($urandom_range(0, 1023)) - 512;
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, i == 0, i == 5, sa[i], sb[i], 1'b1);
    idle(5);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        for (int k = 0; k < 3; k++)
          cycle(k[0] == 1'b0, 1'b1, 1'b1, 8191, 511, 1'b0);
      end
      cycle(1'b1, i == 0, i == 5, sa[i], sb[i], 1'b1);
    end
    idle(5);

    window(100, 100, 3);
    cycle(1'b1, 1'b1, 1'b0, 5000, 300, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 5000, 300, 1'b1);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 300, 200, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, -70, 90, 1'b1);
    idle(5);

    for (int w = 0; w < 40; w++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        longint a, b;
        bit     c, f;
        a = longint'($urandom_range(0, 16383)) - 8192;
        b = longint'($urandom_range(0, 1023)) - 512;
        c = ($urandom_range(0, 9) != 0);
        f = (i == 0) && ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 9) == 0)
          cycle(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, b, 1'b1);
        cycle(1'b1, f, i == n - 1, a, b, c);
        if (!c) i--;
      end
    end
    idle(8);
    check("drain_pending", longint'(pend.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
